id_operand_stage: RTL and testbench

- Parametrised successor to the decode-stage operand/hazard logic: one pipeline stage between fetch/decode and execute.
- Holds one decoded instruction and resolves its two source operands.
- Forwards from NUM_FWD downstream stages, then the writeback port, then the register file.
- Keeps a register scoreboard for long-latency producers (load, mul/div), so consumers interlock even when no forward source currently holds the producer.

---
 rtl/id_operand_stage_if.sv | 60 ++++++
 rtl/id_operand_stage.sv | 122 ++++++++++++
 tb/tb_id_operand_stage.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/id_operand_stage_if.sv
// Bus bundle for the decode/operand stage: upstream, downstream, regfile, forwarding, writeback.
// slave = the stage itself, master = its surroundings.
interface id_operand_stage_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned NumRegs = 1 << REG_AW;

  logic                      flush;
  logic                      in_valid;
  logic                      in_allowin;
  logic [PC_W-1:0]           in_pc;
  logic [REG_AW-1:0]         in_rs1;
  logic [REG_AW-1:0]         in_rs2;
  logic                      in_rs1_en;
  logic                      in_rs2_en;
  logic [REG_AW-1:0]         in_rd;
  logic                      in_rd_we;
  logic                      in_long;
  logic                      out_valid;
  logic                      out_allowin;
  logic [PC_W-1:0]           out_pc;
  logic [DATA_W-1:0]         out_rs1_val;
  logic [DATA_W-1:0]         out_rs2_val;
  logic [REG_AW-1:0]         out_rd;
  logic                      out_rd_we;
  logic                      out_long;
  logic [REG_AW-1:0]         rf_raddr1;
  logic [REG_AW-1:0]         rf_raddr2;
  logic [DATA_W-1:0]         rf_rdata1;
  logic [DATA_W-1:0]         rf_rdata2;
  logic [NUM_FWD-1:0]        fwd_valid;
  logic [NUM_FWD-1:0]        fwd_ready;
  logic [NUM_FWD*REG_AW-1:0] fwd_reg;
  logic [NUM_FWD*DATA_W-1:0] fwd_data;
  logic                      wb_valid;
  logic [REG_AW-1:0]         wb_reg;
  logic [DATA_W-1:0]         wb_data;
  logic [NumRegs-1:0]        sb_busy;
  logic [CNT_W-1:0]          stall_cnt;

  modport slave (
    input  flush, in_valid, in_pc, in_rs1, in_rs2, in_rs1_en, in_rs2_en, in_rd, in_rd_we, in_long,
    input  out_allowin, rf_rdata1, rf_rdata2, fwd_valid, fwd_ready, fwd_reg, fwd_data,
    input  wb_valid, wb_reg, wb_data,
    output in_allowin, out_valid, out_pc, out_rs1_val, out_rs2_val, out_rd, out_rd_we, out_long,
    output rf_raddr1, rf_raddr2, sb_busy, stall_cnt
  );

  modport master (
    output flush, in_valid, in_pc, in_rs1, in_rs2, in_rs1_en, in_rs2_en, in_rd, in_rd_we, in_long,
    output out_allowin, rf_rdata1, rf_rdata2, fwd_valid, fwd_ready, fwd_reg, fwd_data,
    output wb_valid, wb_reg, wb_data,
    input  in_allowin, out_valid, out_pc, out_rs1_val, out_rs2_val, out_rd, out_rd_we, out_long,
    input  rf_raddr1, rf_raddr2, sb_busy, stall_cnt
  );
endinterface

// File: rtl/id_operand_stage.sv
// Decode-to-execute stage: holds one instruction, resolves operands through forwarding,
// writeback bypass and regfile, and interlocks on pending or scoreboarded producers.
module id_operand_stage #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned NUM_FWD = 3,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned CNT_W   = 16
) (
  input logic               clk,
  input logic               reset,
  id_operand_stage_if.slave bus
);
  localparam int unsigned NumRegs = 1 << REG_AW;

  logic                valid_q;
  logic [PC_W-1:0]     pc_q;
  logic [REG_AW-1:0]   rs1_q, rs2_q, rd_q;
  logic                rs1_en_q, rs2_en_q, rd_we_q, long_q;
  logic [NumRegs-1:0]  sb_q, sb_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [DATA_W:0]     res1, res2;
  logic                ready_go, accept, issue;

  // Returns {stall, value}; the lowest-index forward match takes priority.
  function automatic logic [DATA_W:0] resolve(
    input logic [REG_AW-1:0]         rs,
    input logic                      rs_en,
    input logic [DATA_W-1:0]         rf_data,
    input logic [NUM_FWD-1:0]        fv,
    input logic [NUM_FWD-1:0]        fr,
    input logic [NUM_FWD*REG_AW-1:0] freg,
    input logic [NUM_FWD*DATA_W-1:0] fdata,
    input logic                      wv,
    input logic [REG_AW-1:0]         wr,
    input logic [DATA_W-1:0]         wd,
    input logic [NumRegs-1:0]        sb
  );
    logic              hit;
    logic              stall;
    logic [DATA_W-1:0] val;
    hit   = 1'b0;
    stall = 1'b0;
    val   = rf_data;
    if (!rs_en || rs == '0) begin
      val = '0;
    end else begin
      for (int i = 0; i < NUM_FWD; i++) begin
        if (!hit && fv[i] && freg[i*REG_AW +: REG_AW] == rs) begin
          hit   = 1'b1;
          stall = !fr[i];
          val   = fdata[i*DATA_W +: DATA_W];
        end
      end
      if (!hit) begin
        if (wv && wr == rs) val = wd;
        else if (sb[rs])    stall = 1'b1;
      end
    end
    return {stall, val};
  endfunction

  always_comb begin
    res1 = resolve(rs1_q, rs1_en_q, bus.rf_rdata1, bus.fwd_valid, bus.fwd_ready, bus.fwd_reg,
                   bus.fwd_data, bus.wb_valid, bus.wb_reg, bus.wb_data, sb_q);
    res2 = resolve(rs2_q, rs2_en_q, bus.rf_rdata2, bus.fwd_valid, bus.fwd_ready, bus.fwd_reg,
                   bus.fwd_data, bus.wb_valid, bus.wb_reg, bus.wb_data, sb_q);
    ready_go = !(res1[DATA_W] || res2[DATA_W]);
  end

  always_comb begin
    bus.in_allowin  = !valid_q || (bus.out_allowin && ready_go);
    bus.out_valid   = valid_q && ready_go;
    bus.out_pc      = pc_q;
    bus.out_rs1_val = res1[DATA_W-1:0];
    bus.out_rs2_val = res2[DATA_W-1:0];
    bus.out_rd      = rd_q;
    bus.out_rd_we   = rd_we_q;
    bus.out_long    = long_q;
    bus.rf_raddr1   = rs1_q;
    bus.rf_raddr2   = rs2_q;
    bus.sb_busy     = sb_q;
    bus.stall_cnt   = cnt_q;
  end

  assign accept = bus.in_valid && bus.in_allowin;
  assign issue  = bus.out_valid && bus.out_allowin;

  // Clear before set so an issuing long op wins over a same-cycle writeback.
  always_comb begin
    sb_d = sb_q;
    if (bus.wb_valid) sb_d[bus.wb_reg] = 1'b0;
    if (issue && rd_we_q && long_q && rd_q != '0) sb_d[rd_q] = 1'b1;
    sb_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      sb_q    <= '0;
      cnt_q   <= '0;
    end else begin
      if (bus.flush)           valid_q <= 1'b0;
      else if (bus.in_allowin) valid_q <= bus.in_valid;
      sb_q <= sb_d;
      if (valid_q && !ready_go && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      pc_q     <= bus.in_pc;
      rs1_q    <= bus.in_rs1;
      rs2_q    <= bus.in_rs2;
      rs1_en_q <= bus.in_rs1_en;
      rs2_en_q <= bus.in_rs2_en;
      rd_q     <= bus.in_rd;
      rd_we_q  <= bus.in_rd_we;
      long_q   <= bus.in_long;
    end
  end
endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: inputs change on the falling edge, checks follow 1ns later.
module tb_id_operand_stage;
  logic clk = 1'b0;
  logic reset;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  id_operand_stage_if #(.CNT_W(4)) bus ();
  id_operand_stage #(.CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

  // Regfile model: register n reads as 0x1000 + n.
  assign bus.rf_rdata1 = 32'h1000 + 32'(bus.rf_raddr1);
  assign bus.rf_rdata2 = 32'h1000 + 32'(bus.rf_raddr2);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [4:0] rs1, input logic en1,
                           input logic [4:0] rs2, input logic en2, input logic [4:0] rd,
                           input logic we, input logic lng);
    bus.in_pc = pc;   bus.in_rs1 = rs1; bus.in_rs1_en = en1;
    bus.in_rs2 = rs2; bus.in_rs2_en = en2;
    bus.in_rd = rd;   bus.in_rd_we = we; bus.in_long = lng;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    bus.flush = 1'b0; bus.in_valid = 1'b0; bus.out_allowin = 1'b1;
    set_instr(32'h0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.fwd_valid = '0; bus.fwd_ready = '0; bus.fwd_reg = '0; bus.fwd_data = '0;
    bus.wb_valid = 1'b0; bus.wb_reg = '0; bus.wb_data = '0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_sb_busy", 64'(bus.sb_busy), 64'd0);
    chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("rst_in_allowin", 64'(bus.in_allowin), 64'd1);

    // Back-to-back independent ops
    step(); bus.in_valid = 1'b1; set_instr(32'h100, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
    #1 chk("fill_out_valid", 64'(bus.out_valid), 64'd0);
    step(); set_instr(32'h104, 5'd4, 1'b1, 5'd5, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    chk("b2b_a_valid", 64'(bus.out_valid), 64'd1);
    chk("b2b_a_pc", 64'(bus.out_pc), 64'h100);
    chk("b2b_a_rs1", 64'(bus.out_rs1_val), 64'h1001);
    chk("b2b_a_rs2", 64'(bus.out_rs2_val), 64'h1002);
    step(); bus.in_valid = 1'b0;
    #1;
    chk("b2b_b_valid", 64'(bus.out_valid), 64'd1);
    chk("b2b_b_pc", 64'(bus.out_pc), 64'h104);
    chk("b2b_b_rs1", 64'(bus.out_rs1_val), 64'h1004);
    chk("b2b_b_rs2", 64'(bus.out_rs2_val), 64'h1005);
    step(); #1;
    chk("b2b_drain", 64'(bus.out_valid), 64'd0);
    chk("b2b_stall_cnt", 64'(bus.stall_cnt), 64'd0);

    // RAW on r5: youngest forward wins, then older, then writeback
    step(); bus.in_valid = 1'b1; set_instr(32'h200, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    step(); bus.in_valid = 1'b0;
    bus.fwd_valid = 3'b011; bus.fwd_ready = 3'b111;
    bus.fwd_reg = {5'd0, 5'd5, 5'd5};
    bus.fwd_data = {32'h0, 32'hBBBB, 32'hAAAA};
    #1;
    chk("raw_valid", 64'(bus.out_valid), 64'd1);
    chk("raw_youngest", 64'(bus.out_rs1_val), 64'hAAAA);
    chk("raw_rs2_dis", 64'(bus.out_rs2_val), 64'h0);
    bus.fwd_valid = 3'b010;
    #1 chk("raw_older", 64'(bus.out_rs1_val), 64'hBBBB);
    bus.fwd_valid = 3'b000; bus.wb_valid = 1'b1; bus.wb_reg = 5'd5; bus.wb_data = 32'hCCCC;
    #1 chk("raw_wb", 64'(bus.out_rs1_val), 64'hCCCC);

    // Load-use on r7
    step(); bus.wb_valid = 1'b0;
    bus.in_valid = 1'b1; set_instr(32'h300, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    bus.fwd_valid = 3'b001; bus.fwd_ready = 3'b000; bus.fwd_reg = {5'd0, 5'd0, 5'd7};
    bus.fwd_data = '0;
    step(); set_instr(32'h304, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b0, 1'b0);
    #1;
    chk("lu_c1_valid", 64'(bus.out_valid), 64'd0);
    chk("lu_c1_allowin", 64'(bus.in_allowin), 64'd0);
    step(); #1;
    chk("lu_c2_valid", 64'(bus.out_valid), 64'd0);
    chk("lu_c2_allowin", 64'(bus.in_allowin), 64'd0);
    chk("lu_c2_cnt", 64'(bus.stall_cnt), 64'd1);
    step(); bus.fwd_ready = 3'b001; bus.fwd_data = {32'h0, 32'h0, 32'h1234};
    #1;
    chk("lu_cnt", 64'(bus.stall_cnt), 64'd2);
    chk("lu_valid", 64'(bus.out_valid), 64'd1);
    chk("lu_pc", 64'(bus.out_pc), 64'h300);
    chk("lu_rs2", 64'(bus.out_rs2_val), 64'h1234);
    step(); bus.fwd_valid = 3'b000; bus.in_valid = 1'b0;
    #1;
    chk("lu_next_pc", 64'(bus.out_pc), 64'h304);
    chk("lu_next_rs1", 64'(bus.out_rs1_val), 64'h1001);

    // Scoreboard: long op to r9, consumer interlocks until writeback
    step(); bus.in_valid = 1'b1; set_instr(32'h400, 5'd1, 1'b1, 5'd2, 1'b1, 5'd9, 1'b1, 1'b1);
    step(); set_instr(32'h404, 5'd9, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1, 1'b0);
    #1;
    chk("sb_long_valid", 64'(bus.out_valid), 64'd1);
    chk("sb_pre_busy", 64'(bus.sb_busy[9]), 64'd0);
    step(); bus.in_valid = 1'b0;
    #1;
    chk("sb_set", 64'(bus.sb_busy[9]), 64'd1);
    chk("sb_stall", 64'(bus.out_valid), 64'd0);
    chk("sb_allowin", 64'(bus.in_allowin), 64'd0);
    step(); #1 chk("sb_stall2", 64'(bus.out_valid), 64'd0);
    step(); bus.wb_valid = 1'b1; bus.wb_reg = 5'd9; bus.wb_data = 32'h55;
    #1;
    chk("sb_wb_valid", 64'(bus.out_valid), 64'd1);
    chk("sb_wb_pc", 64'(bus.out_pc), 64'h404);
    chk("sb_wb_rs1", 64'(bus.out_rs1_val), 64'h55);
    step(); bus.wb_valid = 1'b0;
    #1;
    chk("sb_clear", 64'(bus.sb_busy[9]), 64'd0);
    chk("sb_cnt", 64'(bus.stall_cnt), 64'd4);

    // Same-cycle set and clear of r9: set wins
    step(); bus.in_valid = 1'b1; set_instr(32'h500, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    step(); set_instr(32'h504, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b1);
    step(); bus.in_valid = 1'b0; bus.wb_valid = 1'b1; bus.wb_reg = 5'd9; bus.wb_data = 32'h66;
    #1;
    chk("sw_busy_before", 64'(bus.sb_busy[9]), 64'd1);
    chk("sw_issue", 64'(bus.out_valid), 64'd1);
    step(); bus.wb_valid = 1'b0;
    #1;
    chk("sw_set_wins", 64'(bus.sb_busy), 64'h200);

    // Register 0 and disabled source never stall
    step(); bus.in_valid = 1'b1; set_instr(32'h600, 5'd0, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 1'b0);
    bus.fwd_valid = 3'b001; bus.fwd_ready = 3'b000; bus.fwd_reg = '0;
    step(); bus.in_valid = 1'b0;
    #1;
    chk("r0_valid", 64'(bus.out_valid), 64'd1);
    chk("r0_rs1", 64'(bus.out_rs1_val), 64'h0);
    chk("r0_rs2_dis", 64'(bus.out_rs2_val), 64'h0);

    // Flush while stalled on r9, then flush against a capture
    step(); bus.fwd_valid = 3'b000;
    bus.in_valid = 1'b1; set_instr(32'h700, 5'd9, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    step(); set_instr(32'h704, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0); bus.flush = 1'b1;
    #1 chk("fl_stalled", 64'(bus.out_valid), 64'd0);
    step(); bus.flush = 1'b0; bus.in_valid = 1'b0;
    #1;
    chk("fl_valid", 64'(bus.out_valid), 64'd0);
    chk("fl_allowin", 64'(bus.in_allowin), 64'd1);
    chk("fl_sb", 64'(bus.sb_busy), 64'h200);
    chk("fl_cnt", 64'(bus.stall_cnt), 64'd5);
    step(); bus.in_valid = 1'b1; set_instr(32'h800, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0);
    bus.flush = 1'b1;
    step(); bus.flush = 1'b0; bus.in_valid = 1'b0;
    #1 chk("fl_drop", 64'(bus.out_valid), 64'd0);

    // Saturation of the 4-bit stall counter
    step(); bus.in_valid = 1'b1; set_instr(32'h900, 5'd9, 1'b1, 5'd0, 1'b0, 5'd1, 1'b1, 1'b0);
    step(); bus.in_valid = 1'b0;
    for (int i = 0; i < 20; i++) step();
    #1;
    chk("sat_cnt", 64'(bus.stall_cnt), 64'd15);
    chk("sat_stalled", 64'(bus.out_valid), 64'd0);

    // Reset mid-stall
    step(); reset = 1'b1;
    step(); reset = 1'b0;
    #1;
    chk("rst2_valid", 64'(bus.out_valid), 64'd0);
    chk("rst2_sb", 64'(bus.sb_busy), 64'd0);
    chk("rst2_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("rst2_allowin", 64'(bus.in_allowin), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
